// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and constants for the SNN timestep scheduler
package snn_pkg;

    localparam int SNN_WIDTH = 16;
    localparam logic [SNN_WIDTH-1:0] VMAX_DEF = 16'h7FFF;
    localparam logic [SNN_WIDTH-1:0] VMIN_DEF = 16'h8000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INTEG  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } snn_state_e;

    typedef struct packed {
        logic [SNN_WIDTH-1:0] threshold;
        logic [SNN_WIDTH-1:0] leak;
        logic [SNN_WIDTH-1:0] refr;
        logic [SNN_WIDTH-1:0] vmax;
        logic [SNN_WIDTH-1:0] vmin;
    } snn_params_t;

    function automatic snn_params_t snn_params_default();
        snn_params_t p;
        p.threshold = '0;
        p.leak      = '0;
        p.refr      = '0;
        p.vmax      = VMAX_DEF;
        p.vmin      = VMIN_DEF;
        return p;
    endfunction

endpackage

// File: rtl/snn_synapse_mem.sv
// rtl/snn_synapse_mem.sv - synapse weight register array, one write port, one async read port
module snn_synapse_mem #(
    parameter int WIDTH    = 16,
    parameter int N_INPUT  = 4,
    parameter int N_OUTPUT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_we,
    input  logic [$clog2(N_INPUT)-1:0]  i_wsrc,
    input  logic [$clog2(N_OUTPUT)-1:0] i_wdst,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic [$clog2(N_INPUT)-1:0]  i_rsrc,
    input  logic [$clog2(N_OUTPUT)-1:0] i_rdst,
    output logic [WIDTH-1:0]            o_rdata
);

    logic signed [WIDTH-1:0] r_w [N_INPUT][N_OUTPUT];
    logic                    w_in_range;

    assign w_in_range = (32'(i_wsrc) < N_INPUT) && (32'(i_wdst) < N_OUTPUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < N_INPUT; s++) begin
                for (int d = 0; d < N_OUTPUT; d++) begin
                    r_w[s][d] <= '0;
                end
            end
        end else if (i_we && w_in_range) begin
            r_w[i_wsrc][i_wdst] <= i_wdata;
        end
    end

    assign o_rdata = r_w[i_rsrc][i_rdst];

endmodule

// File: rtl/snn_step_scheduler.sv
// rtl/snn_step_scheduler.sv - sequences one SNN timestep over a shared accumulate/update datapath
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int WIDTH    = SNN_WIDTH,
    parameter int N_INPUT  = 4,
    parameter int N_OUTPUT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_params,
    input  logic [WIDTH-1:0]            param_threshold,
    input  logic [WIDTH-1:0]            param_leak,
    input  logic [WIDTH-1:0]            param_refr,
    input  logic [WIDTH-1:0]            param_vmax,
    input  logic [WIDTH-1:0]            param_vmin,
    input  logic                        update_synapse,
    input  logic [$clog2(N_INPUT)-1:0]  syn_src,
    input  logic [$clog2(N_OUTPUT)-1:0] syn_dst,
    input  logic [WIDTH-1:0]            syn_weight,
    input  logic                        net_reset,
    input  logic                        step_start,
    input  logic [N_INPUT-1:0]          spike_in,
    output logic                        step_busy,
    output logic                        step_done,
    output logic [N_OUTPUT-1:0]         spike_out,
    output logic                        syn_overflow
);

    localparam int SW = $clog2(N_INPUT);
    localparam int DW = $clog2(N_OUTPUT);
    localparam int AW = WIDTH + SW + 1;
    localparam int TW = AW + 2;

    snn_state_e              r_state, w_state_next;
    snn_params_t             r_live, r_snap;
    logic [N_INPUT-1:0]      r_spk;
    logic [SW-1:0]           r_i;
    logic [DW-1:0]           r_j;
    logic signed [AW-1:0]    r_acc;
    logic [N_OUTPUT-1:0]     r_spk_new, r_spike_out;
    logic signed [WIDTH-1:0] r_v    [N_OUTPUT];
    logic [WIDTH-1:0]        r_refr [N_OUTPUT];
    logic                    r_pend_valid;
    logic [SW-1:0]           r_pend_src;
    logic [DW-1:0]           r_pend_dst;
    logic [WIDTH-1:0]        r_pend_w;
    logic                    r_ovf;

    logic                    w_last_i, w_last_j, w_syn_ok, w_defer;
    logic                    w_mem_we;
    logic [SW-1:0]           w_mem_src;
    logic [DW-1:0]           w_mem_dst;
    logic [WIDTH-1:0]        w_mem_wdata, w_rd;
    logic signed [AW-1:0]    w_wext;
    logic signed [TW-1:0]    w_t, w_tc, w_vmax_ext, w_vmin_ext, w_thr_ext;
    logic                    w_fire;
    logic [N_OUTPUT-1:0]     w_spk_next;

    assign w_last_i = (r_i == SW'(N_INPUT - 1));
    assign w_last_j = (r_j == DW'(N_OUTPUT - 1));
    assign w_syn_ok = update_synapse && (32'(syn_src) < N_INPUT) && (32'(syn_dst) < N_OUTPUT);
    assign w_defer  = (r_state == INTEG) || (r_state == UPDATE);

    // Writes landing mid-step are parked so the running step sees a stable weight set.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_src   = syn_src;
        w_mem_dst   = syn_dst;
        w_mem_wdata = syn_weight;
        if (w_syn_ok && !w_defer) begin
            w_mem_we = 1'b1;
        end else if ((r_state == DONE) && r_pend_valid && !net_reset) begin
            w_mem_we    = 1'b1;
            w_mem_src   = r_pend_src;
            w_mem_dst   = r_pend_dst;
            w_mem_wdata = r_pend_w;
        end
    end

    snn_synapse_mem #(
        .WIDTH    (WIDTH),
        .N_INPUT  (N_INPUT),
        .N_OUTPUT (N_OUTPUT)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_wsrc  (w_mem_src),
        .i_wdst  (w_mem_dst),
        .i_wdata (w_mem_wdata),
        .i_rsrc  (r_i),
        .i_rdst  (r_j),
        .o_rdata (w_rd)
    );

    assign w_wext = AW'($signed(w_rd));

    // Membrane update evaluated wide enough that v + acc - leak can never wrap before clamping.
    assign w_vmax_ext = TW'($signed(r_snap.vmax));
    assign w_vmin_ext = TW'($signed(r_snap.vmin));
    assign w_thr_ext  = TW'(r_snap.threshold);
    assign w_t        = TW'(r_v[r_j]) + TW'(r_acc) - TW'(r_snap.leak);
    assign w_tc       = (w_t > w_vmax_ext) ? w_vmax_ext :
                        (w_t < w_vmin_ext) ? w_vmin_ext : w_t;
    assign w_fire     = (w_tc >= w_thr_ext);

    always_comb begin
        w_spk_next      = r_spk_new;
        w_spk_next[r_j] = (r_refr[r_j] == '0) && w_fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (step_start) w_state_next = INTEG;
            INTEG:   if (w_last_i) w_state_next = UPDATE;
            UPDATE:  w_state_next = w_last_j ? DONE : INTEG;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (net_reset) w_state_next = IDLE;
    end

    always_comb begin
        step_busy = (r_state == INTEG) || (r_state == UPDATE);
        step_done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_live       <= snn_params_default();
            r_snap       <= snn_params_default();
            r_spk        <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_acc        <= '0;
            r_spk_new    <= '0;
            r_spike_out  <= '0;
            r_pend_valid <= 1'b0;
            r_pend_src   <= '0;
            r_pend_dst   <= '0;
            r_pend_w     <= '0;
            r_ovf        <= 1'b0;
            for (int k = 0; k < N_OUTPUT; k++) begin
                r_v[k]    <= '0;
                r_refr[k] <= '0;
            end
        end else begin
            if (load_params) begin
                r_live.threshold <= param_threshold;
                r_live.leak      <= param_leak;
                r_live.refr      <= param_refr;
                r_live.vmax      <= param_vmax;
                r_live.vmin      <= param_vmin;
            end
            if (net_reset) begin
                for (int k = 0; k < N_OUTPUT; k++) begin
                    r_v[k]    <= '0;
                    r_refr[k] <= '0;
                end
                r_spike_out  <= '0;
                r_pend_valid <= 1'b0;
                r_i          <= '0;
                r_j          <= '0;
                r_acc        <= '0;
            end else begin
                if (w_syn_ok && w_defer) begin
                    r_pend_valid <= 1'b1;
                    r_pend_src   <= syn_src;
                    r_pend_dst   <= syn_dst;
                    r_pend_w     <= syn_weight;
                    if (r_pend_valid) r_ovf <= 1'b1;
                end
                case (r_state)
                    IDLE: begin
                        if (step_start) begin
                            r_spk     <= spike_in;
                            r_snap    <= r_live;
                            r_i       <= '0;
                            r_j       <= '0;
                            r_acc     <= '0;
                            r_spk_new <= '0;
                        end
                    end
                    INTEG: begin
                        if (r_spk[r_i]) r_acc <= r_acc + w_wext;
                        r_i <= w_last_i ? '0 : r_i + SW'(1);
                    end
                    UPDATE: begin
                        if (r_refr[r_j] != '0) begin
                            r_refr[r_j] <= r_refr[r_j] - WIDTH'(1);
                            r_v[r_j]    <= '0;
                        end else if (w_fire) begin
                            r_v[r_j]    <= '0;
                            r_refr[r_j] <= r_snap.refr;
                        end else begin
                            r_v[r_j]    <= w_tc[WIDTH-1:0];
                        end
                        r_spk_new <= w_spk_next;
                        r_i       <= '0;
                        r_acc     <= '0;
                        if (w_last_j) begin
                            r_j         <= '0;
                            r_spike_out <= w_spk_next;
                        end else begin
                            r_j <= r_j + DW'(1);
                        end
                    end
                    DONE:    r_pend_valid <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign spike_out    = r_spike_out;
    assign syn_overflow = r_ovf;

endmodule
